// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared constants and state type for the masked 1R1W memory controller
package mem_ctrl_pkg;
    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;
    localparam int WIDTH  = 64;
    localparam int MASK_W = 8;
    localparam int LANE_W = WIDTH / MASK_W;

    typedef enum logic {
        INIT,
        RUN
    } state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter, pointer moves past the grantee when advance is set
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] idx;
    logic [PW-1:0] gidx;
    logic          found;

    always_comb begin
        gnt   = '0;
        gidx  = ptr;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = PW'((int'(ptr) + k) % N);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                gidx     = idx;
                found    = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= (gidx == PW'(N - 1)) ? '0 : gidx + 1'b1;
        end
    end
endmodule

// File: rtl/mem_1r1w_masked_ctrl.sv
// rtl/mem_1r1w_masked_ctrl.sv - zero-inits a 1R1W masked memory, then arbitrates reads and writes independently
module mem_1r1w_masked_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int DEPTH  = mem_ctrl_pkg::DEPTH,
    parameter int ADDR_W = mem_ctrl_pkg::ADDR_W,
    parameter int WIDTH  = mem_ctrl_pkg::WIDTH,
    parameter int MASK_W = mem_ctrl_pkg::MASK_W
) (
    input  logic                   clock,
    input  logic                   reset,
    output logic                   init_busy,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ-1:0]        req_write,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*WIDTH-1:0]  req_wdata,
    input  logic [NREQ*MASK_W-1:0] req_mask,
    output logic [NREQ-1:0]        resp_valid,
    output logic [WIDTH-1:0]       resp_data,
    output logic [ADDR_W-1:0]      R0_addr,
    output logic                   R0_en,
    input  logic [WIDTH-1:0]       R0_data,
    output logic [ADDR_W-1:0]      W0_addr,
    output logic                   W0_en,
    output logic [WIDTH-1:0]       W0_data,
    output logic [MASK_W-1:0]      W0_mask
);
    state_t              state, state_nx;
    logic [ADDR_W-1:0]   init_cnt, init_cnt_nx;
    logic                run;

    logic [NREQ-1:0]     rd_req, wr_req, rd_gnt, wr_gnt, rd_gnt_eff;
    logic [ADDR_W-1:0]   rd_addr, wr_addr;
    logic [WIDTH-1:0]    wr_data;
    logic [MASK_W-1:0]   wr_mask;
    logic                collide;

    logic [ADDR_W-1:0]   r_addr_q, w_addr_q;
    logic [WIDTH-1:0]    w_data_q, data_hold;
    logic [MASK_W-1:0]   w_mask_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= INIT;
            init_cnt <= '0;
        end else begin
            state    <= state_nx;
            init_cnt <= init_cnt_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        init_cnt_nx = init_cnt;
        init_busy   = (state == INIT);
        if (state == INIT) begin
            init_cnt_nx = init_cnt + 1'b1;
            if (init_cnt == ADDR_W'(DEPTH - 1)) begin
                state_nx = RUN;
            end
        end
    end

    assign run    = (state == RUN);
    assign rd_req = run ? (req_valid & ~req_write) : '0;
    assign wr_req = run ? (req_valid &  req_write) : '0;

    rr_arbiter #(.N(NREQ)) u_rd_arb (
        .clock   (clock),
        .reset   (reset),
        .req     (rd_req),
        .advance (!collide),
        .gnt     (rd_gnt)
    );

    rr_arbiter #(.N(NREQ)) u_wr_arb (
        .clock   (clock),
        .reset   (reset),
        .req     (wr_req),
        .advance (1'b1),
        .gnt     (wr_gnt)
    );

    always_comb begin
        rd_addr = '0;
        wr_addr = '0;
        wr_data = '0;
        wr_mask = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (rd_gnt[i]) rd_addr = req_addr[i*ADDR_W +: ADDR_W];
            if (wr_gnt[i]) begin
                wr_addr = req_addr[i*ADDR_W +: ADDR_W];
                wr_data = req_wdata[i*WIDTH +: WIDTH];
                wr_mask = req_mask[i*MASK_W +: MASK_W];
            end
        end
    end

    // A same-address read waits a cycle so it observes the write instead of racing it
    assign collide    = (|rd_gnt) && (|wr_gnt) && (rd_addr == wr_addr);
    assign rd_gnt_eff = collide ? '0 : rd_gnt;
    assign req_ready  = rd_gnt_eff | wr_gnt;

    always_comb begin
        R0_en   = |rd_gnt_eff;
        R0_addr = R0_en ? rd_addr : r_addr_q;
        if (init_busy) begin
            W0_en   = 1'b1;
            W0_addr = init_cnt;
            W0_data = '0;
            W0_mask = '1;
        end else if (|wr_gnt) begin
            W0_en   = 1'b1;
            W0_addr = wr_addr;
            W0_data = wr_data;
            W0_mask = wr_mask;
        end else begin
            W0_en   = 1'b0;
            W0_addr = w_addr_q;
            W0_data = w_data_q;
            W0_mask = w_mask_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_addr_q   <= '0;
            w_addr_q   <= '0;
            w_data_q   <= '0;
            w_mask_q   <= '0;
            resp_valid <= '0;
            data_hold  <= '0;
        end else begin
            r_addr_q   <= R0_addr;
            w_addr_q   <= W0_addr;
            w_data_q   <= W0_data;
            w_mask_q   <= W0_mask;
            resp_valid <= rd_gnt_eff;
            if (|resp_valid) data_hold <= R0_data;
        end
    end

    // Read data passes straight through in the response cycle; the register only holds it afterwards
    assign resp_data = (|resp_valid) ? R0_data : data_hold;
endmodule

// File: tb/tb_mem_1r1w_masked_ctrl.sv
// tb/tb_mem_1r1w_masked_ctrl.sv - scoreboard bench for mem_1r1w_masked_ctrl with a behavioural memory
module tb_mem_1r1w_masked_ctrl;
    localparam int NREQ   = 2;
    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;
    localparam int WIDTH  = 64;
    localparam int MASK_W = 8;

    logic                   clock = 1'b0;
    logic                   reset;
    logic                   init_busy;
    logic [NREQ-1:0]        req_valid, req_ready, req_write, resp_valid;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*WIDTH-1:0]  req_wdata;
    logic [NREQ*MASK_W-1:0] req_mask;
    logic [WIDTH-1:0]       resp_data, R0_data, W0_data;
    logic [ADDR_W-1:0]      R0_addr, W0_addr;
    logic                   R0_en, W0_en;
    logic [MASK_W-1:0]      W0_mask;

    always #5 clock = ~clock;

    mem_1r1w_masked_ctrl #(
        .NREQ(NREQ), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .WIDTH(WIDTH), .MASK_W(MASK_W)
    ) dut (
        .clock(clock), .reset(reset), .init_busy(init_busy),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_mask(req_mask),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .R0_addr(R0_addr), .R0_en(R0_en), .R0_data(R0_data),
        .W0_addr(W0_addr), .W0_en(W0_en), .W0_data(W0_data), .W0_mask(W0_mask)
    );

    logic [WIDTH-1:0] mem     [DEPTH];
    logic [WIDTH-1:0] ref_mem [DEPTH];

    always @(posedge clock) begin
        if (R0_en) R0_data <= mem[R0_addr];
        if (W0_en) begin
            for (int k = 0; k < MASK_W; k++) begin
                if (W0_mask[k]) mem[W0_addr][8*k +: 8] <= W0_data[8*k +: 8];
            end
        end
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        int              due;
        logic [NREQ-1:0] id;
        logic [WIDTH-1:0] data;
    } exp_t;
    exp_t sb[$];

    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (resp_valid != '0) begin
                if (sb.size() == 0) begin
                    check("resp_unexpected", 64'(resp_valid), 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("resp_id", 64'(resp_valid), 64'(e.id));
                    check("resp_data", resp_data, e.data);
                    check("resp_latency", 64'(cyc), 64'(e.due));
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                check("resp_missing", 64'(resp_valid), 64'(sb[0].id));
                void'(sb.pop_front());
            end
        end
    end

    task automatic set_req(input int i, input logic v, input logic w, input logic [ADDR_W-1:0] a,
                           input logic [WIDTH-1:0] d, input logic [MASK_W-1:0] m);
        req_valid[i] = v;
        req_write[i] = w;
        req_addr[i*ADDR_W +: ADDR_W] = a;
        req_wdata[i*WIDTH +: WIDTH]  = d;
        req_mask[i*MASK_W +: MASK_W] = m;
    endtask

    task automatic idle_all();
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 1'b0, '0, '0, '0);
    endtask

    // One cycle: check expected grants, push expected reads, then apply expected writes to the model
    task automatic step(input logic [NREQ-1:0] exp_ready, input bit track);
        logic [ADDR_W-1:0] a;
        @(negedge clock);
        check("req_ready", 64'(req_ready), 64'(exp_ready));
        if (track) begin
            for (int i = 0; i < NREQ; i++) begin
                a = req_addr[i*ADDR_W +: ADDR_W];
                if (exp_ready[i] && !req_write[i])
                    sb.push_back('{cyc + 1, NREQ'(1 << i), ref_mem[a]});
            end
            for (int i = 0; i < NREQ; i++) begin
                a = req_addr[i*ADDR_W +: ADDR_W];
                if (exp_ready[i] && req_write[i]) begin
                    for (int k = 0; k < MASK_W; k++)
                        if (req_mask[i*MASK_W + k]) ref_mem[a][8*k +: 8] = req_wdata[i*WIDTH + 8*k +: 8];
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        for (int j = 0; j < DEPTH; j++) begin
            mem[j]     = 64'hDEAD_BEEF_0000_0000 | 64'(j);
            ref_mem[j] = '0;
        end
        R0_data = '0;
        reset = 1'b1;
        idle_all();
        repeat (2) @(posedge clock);
        #1;

        @(negedge clock);
        check("rst_init_busy", 64'(init_busy), 64'd1);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_data", resp_data, 64'd0);
        check("rst_R0_en", 64'(R0_en), 64'd0);
        check("rst_W0_en", 64'(W0_en), 64'd1);
        check("rst_W0_addr", 64'(W0_addr), 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Zero-init sweep with a read already waiting
        set_req(0, 1'b1, 1'b0, 5'd0, '0, '0);
        for (int c = 0; c < DEPTH; c++) begin
            @(negedge clock);
            check("init_busy", 64'(init_busy), 64'd1);
            check("init_W0_en", 64'(W0_en), 64'd1);
            check("init_W0_addr", 64'(W0_addr), 64'(c));
            check("init_W0_data", W0_data, 64'd0);
            check("init_W0_mask", 64'(W0_mask), 64'hFF);
            check("init_req_ready", 64'(req_ready), 64'd0);
            check("init_R0_en", 64'(R0_en), 64'd0);
            @(posedge clock);
            #1;
        end
        step(2'b01, 1'b1);
        idle_all();
        @(negedge clock);
        check("run_init_busy", 64'(init_busy), 64'd0);
        @(posedge clock);
        #1;
        repeat (2) step(2'b00, 1'b1);

        // Full write then read by the other requester, plus the hold of resp_data
        set_req(0, 1'b1, 1'b1, 5'd5, 64'h1122334455667788, 8'hFF);
        step(2'b01, 1'b1);
        idle_all();
        step(2'b00, 1'b1);
        set_req(1, 1'b1, 1'b0, 5'd5, '0, '0);
        step(2'b10, 1'b1);
        idle_all();
        step(2'b00, 1'b1);
        @(negedge clock);
        check("hold_resp_data", resp_data, 64'h1122334455667788);
        check("hold_resp_valid", 64'(resp_valid), 64'd0);
        @(posedge clock);
        #1;

        // Partial mask, then an all-zero mask which must leave the word alone
        set_req(0, 1'b1, 1'b1, 5'd7, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
        step(2'b01, 1'b1);
        idle_all();
        set_req(1, 1'b1, 1'b0, 5'd7, '0, '0);
        step(2'b10, 1'b1);
        idle_all();
        set_req(0, 1'b1, 1'b1, 5'd7, 64'h1234, 8'h00);
        step(2'b01, 1'b1);
        idle_all();
        set_req(1, 1'b1, 1'b0, 5'd7, '0, '0);
        step(2'b10, 1'b1);
        idle_all();
        step(2'b00, 1'b1);
        check("mask_model", ref_mem[7], 64'h0000_0000_FFFF_FFFF);

        // Both requesters reading continuously alternate grants
        set_req(0, 1'b1, 1'b0, 5'd5, '0, '0);
        set_req(1, 1'b1, 1'b0, 5'd7, '0, '0);
        for (int r = 0; r < 6; r++) step((r % 2 == 0) ? 2'b01 : 2'b10, 1'b1);
        idle_all();
        step(2'b00, 1'b1);

        // Same-address read/write collision, then a non-colliding pair
        set_req(0, 1'b1, 1'b1, 5'd3, 64'hA5A5_0000_5A5A_1111, 8'hFF);
        set_req(1, 1'b1, 1'b0, 5'd3, '0, '0);
        step(2'b01, 1'b1);
        set_req(0, 1'b0, 1'b0, '0, '0, '0);
        step(2'b10, 1'b1);
        set_req(0, 1'b1, 1'b1, 5'd9, 64'h0909_0909_0909_0909, 8'hFF);
        set_req(1, 1'b1, 1'b0, 5'd5, '0, '0);
        step(2'b11, 1'b1);
        idle_all();
        step(2'b00, 1'b1);

        // Two writers: write pointer sits at requester 1 after only requester 0 has written
        set_req(0, 1'b1, 1'b1, 5'd10, 64'h1010_1010_1010_1010, 8'hFF);
        set_req(1, 1'b1, 1'b1, 5'd11, 64'h1111_1111_1111_1111, 8'hF0);
        step(2'b10, 1'b1);
        step(2'b01, 1'b1);
        set_req(0, 1'b1, 1'b0, 5'd10, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0, '0);
        step(2'b01, 1'b1);
        set_req(0, 1'b1, 1'b0, 5'd11, '0, '0);
        step(2'b01, 1'b1);
        idle_all();
        step(2'b00, 1'b1);

        // Reset while a read is being granted: its response must be dropped
        set_req(0, 1'b1, 1'b0, 5'd3, '0, '0);
        reset = 1'b1;
        step(2'b01, 1'b0);
        idle_all();
        for (int j = 0; j < DEPTH; j++) ref_mem[j] = '0;
        @(negedge clock);
        check("rrst_resp_valid", 64'(resp_valid), 64'd0);
        check("rrst_init_busy", 64'(init_busy), 64'd1);
        check("rrst_W0_addr", 64'(W0_addr), 64'd0);
        check("rrst_W0_en", 64'(W0_en), 64'd1);
        check("rrst_R0_en", 64'(R0_en), 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (DEPTH) step(2'b00, 1'b1);
        set_req(1, 1'b1, 1'b0, 5'd5, '0, '0);
        step(2'b10, 1'b1);
        idle_all();
        repeat (3) step(2'b00, 1'b1);

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_1r1w_masked_ctrl.md
# mem_1r1w_masked_ctrl

Controller that shares one `mem_1r1w_masked` instance (32 x 64, 8-bit mask granularity, one read port, one masked write port) between `NREQ` requesters. After reset it zero-initialises the array. It then round-robin arbitrates reads and writes independently, so one read and one write can issue per cycle, and returns read data with fixed latency. It sits between client pipelines and the memory wrapper; the wrapper's `R0_clk`/`W0_clk` are tied to `clock` by the parent.

## Interface
- `NREQ`, 2, number of requesters (2..4)
- `DEPTH`, 32, memory words
- `ADDR_W`, 5, log2(`DEPTH`)
- `WIDTH`, 64, data bits
- `MASK_W`, 8, mask bits; one bit per `WIDTH/MASK_W`-bit lane
- `clock`  in  1  sole clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `init_busy`  out  1  high while the zero-init sweep runs
- `req_valid`  in  NREQ  request present, one bit per requester
- `req_ready`  out  NREQ  request accepted this cycle (valid && ready = grant)
- `req_write`  in  NREQ  1 = write, 0 = read
- `req_addr`  in  NREQ*ADDR_W  packed; requester i at [i*ADDR_W +: ADDR_W]
- `req_wdata`  in  NREQ*WIDTH  packed write data
- `req_mask`  in  NREQ*MASK_W  packed byte-lane enables
- `resp_valid`  out  NREQ  one-hot read response strobe
- `resp_data`  out  WIDTH  read data, shared by all requesters
- `R0_addr` out ADDR_W, `R0_en` out 1, `R0_data` in WIDTH: memory read port
- `W0_addr` out ADDR_W, `W0_en` out 1, `W0_data` out WIDTH, `W0_mask` out MASK_W: memory write port

## Operation
- **States:**
  - INIT: entered on reset. Issues `W0_en`=1, `W0_mask`=all ones, `W0_data`=0 to addresses 0..DEPTH-1, one per cycle. `init_busy`=1, `req_ready`=0, `R0_en`=0.
  - RUN: entered after address DEPTH-1 is written. Never left except by reset.
- **Arbitration (RUN only):**
  - Two independent round-robin arbiters: read (requesters with valid && !write) and write (valid && write).
  - Each arbiter grants at most one requester per cycle.
  - Each arbiter's priority pointer moves to grantee+1 (mod NREQ) after a grant and holds otherwise. Both pointers reset to 0.
  - A requester gets at most one grant per cycle, since it presents one op.
- **Write:** the grant drives `W0_en`=1 with the grantee's addr/data/mask. Mask bit k enables `W0_data[8k+7:8k]`. A mask of 0 is still issued (no-op write).
- **Read:** the grant drives `R0_en`=1 and `R0_addr` for the grantee. The grantee id is registered for the response.
- **Collision:** if the winning read and the winning write target the same address in the same cycle, the read grant is suppressed: `req_ready` stays low for that reader and its pointer does not move. The write proceeds. The read is granted in a later cycle and returns the new data.
- **Idle ports:** with no grant, `R0_en`/`W0_en`=0. Other memory outputs are don't-care but are driven deterministically (hold last value).
- **Responses:** no backpressure. Requesters must accept `resp_valid` unconditionally.

## Timing
- Reset values:
  - `init_busy`=1, `req_ready`=0, `resp_valid`=0, `resp_data`=0.
  - `R0_en`=0, `W0_en`=1 (INIT at address 0), init counter=0.
- INIT lasts exactly DEPTH cycles. First cycle in which `req_ready` can be 1 is cycle DEPTH after reset deassertion.
- Read: grant in cycle N → memory samples at edge N+1 → `R0_data` valid in cycle N+1. `resp_valid[id]`=1 and `resp_data`=`R0_data` in cycle N+1. `resp_data` is registered in cycle N+2 only for hold; `resp_valid` is a 1-cycle pulse.
- Back-to-back reads give one response per cycle, in grant order.
- A write granted in cycle N is visible to a read granted in cycle N+1 or later.
- `req_ready` is combinational from `req_valid`, `req_write`, `req_addr` and the pointers. It does not depend on `resp_*`.
- Reset asserted mid-INIT or mid-RUN: next cycle is INIT at address 0. Pending responses are dropped (`resp_valid`=0).

## Structure
- Package `mem_ctrl_pkg`: `DEPTH`/`ADDR_W`/`WIDTH`/`MASK_W` defaults, state enum {INIT, RUN}, lane width constant.
- Sub-module `rr_arbiter` (params `N`; in `req[N]`, `advance`; out one-hot `gnt[N]`; internal pointer). Instantiated twice, for read and write.

## Test plan
- Reset, then idle for 40 cycles → `init_busy` high for exactly 32 cycles, `W0_en`=1 with addresses 0..31 and data 0, then `req_ready` responds.
- Requester 0 writes 0x1122334455667788 to addr 5, mask 0xFF; requester 1 later reads addr 5 → `resp_valid`=2'b10 one cycle after the grant, data 0x1122334455667788.
- Write addr 7 with data 0xFFFF_FFFF_FFFF_FFFF, mask 0x0F, over an all-zero word, then read → 0x00000000FFFFFFFF.
- Both requesters read continuously → grants alternate 0,1,0,1…; responses are one-hot in the same order with 1-cycle latency.
- Requester 0 writes addr 3 and requester 1 reads addr 3 in the same cycle → read ready=0 that cycle, granted next cycle, returns the new data.
- Assert reset in RUN with a read response pending → `resp_valid`=0 next cycle, INIT restarts at address 0.
